// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared types and doorbell frame field layout for the
// SPI capture block and the signal decoder.
package spi_frame_pkg;

   localparam int FRAME_BITS = 40;
   localparam int COUNT_W    = 6;
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_e;

   localparam int TONE0_LSB = 36;
   localparam int DUR0_LSB  = 32;
   localparam int TONE1_LSB = 28;
   localparam int DUR1_LSB  = 24;
   localparam int TONE2_LSB = 20;
   localparam int DUR2_LSB  = 16;
   localparam int TONE3_LSB = 12;
   localparam int DUR3_LSB  = 8;
   localparam int REP_LSB   = 0;
   localparam int NIB_W     = 4;
   localparam int REP_W     = 8;

   typedef struct packed {
      logic [NIB_W-1:0] tone0;
      logic [NIB_W-1:0] dur0;
      logic [NIB_W-1:0] tone1;
      logic [NIB_W-1:0] dur1;
      logic [NIB_W-1:0] tone2;
      logic [NIB_W-1:0] dur2;
      logic [NIB_W-1:0] tone3;
      logic [NIB_W-1:0] dur3;
      logic [REP_W-1:0] rep_threshold;
   } frame_fields_t;

   function automatic frame_fields_t unpack_frame(
      input logic [FRAME_BITS-1:0] f
   );
      return frame_fields_t'(f);
   endfunction

   function automatic logic [NIB_W-1:0] tone_of(
      input frame_fields_t f,
      input logic [1:0]    idx
   );
      logic [NIB_W-1:0] t;
      t = f.tone0;
      unique case (idx)
         2'd0: t = f.tone0;
         2'd1: t = f.tone1;
         2'd2: t = f.tone2;
         2'd3: t = f.tone3;
         default: t = f.tone0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with edge detect; edges are held off
// until the chain and its delayed copy carry real pin history after reset.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   dly;
   logic [SYNC_STAGES:0]   prime;
   logic                   armed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         dly   <= 1'b0;
         prime <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
         dly   <= chain[SYNC_STAGES-1];
         prime <= {prime[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // a pin already high at reset release must not look like a rising edge
   assign armed = prime[SYNC_STAGES];
   assign level = chain[SYNC_STAGES-1];
   assign rise  = armed & level & ~dly;
   assign fall  = armed & ~level & dly;

endmodule

// File: rtl/spi_frame_capture.sv
// spi_frame_capture: oversampled SPI mode-0 frame receiver with valid/ready
// delivery. SPI_FRAME_OVERWRITE_EN: newer good frame replaces a pending one.
module spi_frame_capture #(
   parameter int FRAME_BITS  = spi_frame_pkg::FRAME_BITS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  int_osc,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  ce,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic                  busy,
   output logic                  frame_error,
   output logic                  frame_drop
);

   import spi_frame_pkg::*;

   localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FRAME_BITS);

   state_e                state;
   state_e                state_nxt;
   logic [FRAME_BITS-1:0] shift_q;
   logic [COUNT_W-1:0]    count_q;

   logic sck_s, sck_rise, sck_fall;
   logic sdi_s, sdi_rise, sdi_fall;
   logic ce_s, ce_rise, ce_fall;
   logic unused_edges;

   logic len_ok;
   logic do_load;
   logic do_drop;
   logic do_error;
   logic consume;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
      .clk   (int_osc),
      .rst   (reset),
      .d     (sck),
      .level (sck_s),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
      .clk   (int_osc),
      .rst   (reset),
      .d     (sdi),
      .level (sdi_s),
      .rise  (sdi_rise),
      .fall  (sdi_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ce (
      .clk   (int_osc),
      .rst   (reset),
      .d     (ce),
      .level (ce_s),
      .rise  (ce_rise),
      .fall  (ce_fall)
   );

   assign unused_edges = ^{sdi_rise, sdi_fall, sck_fall, sck_s, ce_s};

   always_ff @(posedge int_osc or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (ce_rise) state_nxt = SHIFT;
         SHIFT:   if (ce_fall) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == SHIFT);
      consume  = frame_valid & frame_ready;
      len_ok   = (count_q == FULL_COUNT);
      do_load  = 1'b0;
      do_drop  = 1'b0;
      do_error = 1'b0;
      if (state == CHECK) begin
         unique case (1'b1)
            !len_ok: do_error = 1'b1;
            len_ok && (!frame_valid || frame_ready): do_load = 1'b1;
            default: begin
               do_drop = 1'b1;
`ifdef SPI_FRAME_OVERWRITE_EN
               do_load = 1'b1;
`else
               do_load = 1'b0;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge int_osc or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         count_q <= '0;
      end else if (state == IDLE && ce_rise) begin
         shift_q <= '0;
         count_q <= '0;
      end else if (state == SHIFT && sck_rise) begin
         shift_q <= {shift_q[FRAME_BITS-2:0], sdi_s};
         if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
      end
   end

   // a load in the same cycle as a consume keeps frame_valid high
   always_ff @(posedge int_osc or posedge reset) begin
      if (reset) begin
         frame       <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         frame_drop  <= 1'b0;
      end else begin
         frame_error <= do_error;
         frame_drop  <= do_drop;
         if (do_load) begin
            frame       <= shift_q;
            frame_valid <= 1'b1;
         end else if (consume) begin
            frame_valid <= 1'b0;
         end
      end
   end

   a_err_drop_excl: assert property (
      @(posedge int_osc) disable iff (reset)
      !(frame_error && frame_drop)
   );

   a_frame_stable: assert property (
      @(posedge int_osc) disable iff (reset)
      !do_load |=> $stable(frame)
   );

endmodule

// File: tb/tb_spi_frame_capture.sv
// tb_spi_frame_capture: scoreboard bench for spi_frame_capture; expected
// deliver/error/drop events are queued at stimulus time and popped on output.
module tb_spi_frame_capture;

   localparam int FB   = 40;
   localparam int SYNC = 2;
   localparam int HALF = 4;

   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_DELIVER = 2'd1,
      EV_ERROR   = 2'd2,
      EV_DROP    = 2'd3
   } ev_kind_e;

   typedef struct packed {
      ev_kind_e      kind;
      logic [FB-1:0] data;
   } ev_t;

   logic          int_osc;
   logic          reset;
   logic          sck;
   logic          sdi;
   logic          ce;
   logic [FB-1:0] frame;
   logic          frame_valid;
   logic          frame_ready;
   logic          busy;
   logic          frame_error;
   logic          frame_drop;

   int total;
   int bad;
   ev_t sb[$];

   logic          prev_valid;
   logic [FB-1:0] prev_frame;

   spi_frame_capture #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
      .int_osc     (int_osc),
      .reset       (reset),
      .sck         (sck),
      .sdi         (sdi),
      .ce          (ce),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .busy        (busy),
      .frame_error (frame_error),
      .frame_drop  (frame_drop)
   );

   initial int_osc = 1'b0;
   always #5 int_osc = ~int_osc;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge int_osc);
   endtask

   task automatic spi_bits(input logic [63:0] data, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sdi = data[i];
         cycles(HALF);
         sck = 1'b1;
         cycles(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic spi_send(input logic [63:0] data, input int n);
      ce = 1'b1;
      cycles(HALF);
      spi_bits(data, n);
      cycles(HALF);
      ce = 1'b0;
   endtask

   task automatic expect_ev(input ev_kind_e k, input logic [FB-1:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      sb.push_back(e);
   endtask

   always @(negedge int_osc) begin
      ev_t      e;
      ev_kind_e k;
      logic     has;
      if (reset) begin
         prev_valid = 1'b0;
         prev_frame = '0;
      end else begin
         has = 1'b1;
         k   = EV_NONE;
         if (frame_error)      k = EV_ERROR;
         else if (frame_drop)  k = EV_DROP;
         else if (frame_valid && (!prev_valid || frame != prev_frame))
            k = EV_DELIVER;
         else has = 1'b0;
         if (has) begin
            e.kind = EV_NONE;
            e.data = '0;
            if (sb.size() > 0) e = sb.pop_front();
            check("ev_kind", 64'(k), 64'(e.kind));
            if (k != EV_ERROR) check("ev_frame", 64'(frame), 64'(e.data));
         end
         prev_valid = frame_valid;
         prev_frame = frame;
      end
   end

   initial begin
      logic [FB-1:0] f1, fa, fb, fa2, fb2, f6;
      int cyc;
      total       = 0;
      bad         = 0;
      prev_valid  = 1'b0;
      prev_frame  = '0;
      f1  = 40'h759A2B4C03;
      fa  = 40'h123456789A;
      fb  = 40'hFEDCBA9876;
      fa2 = 40'h0F0F0F0F0F;
      fb2 = 40'hA5A5A5A5A5;
      f6  = 40'h3C96E1D24B;
      reset       = 1'b1;
      sck         = 1'b0;
      sdi         = 1'b0;
      ce          = 1'b0;
      frame_ready = 1'b1;
      cycles(4);
      reset = 1'b0;
      cycles(4);

      check("rst_frame", 64'(frame), 64'h0);
      check("rst_valid", 64'(frame_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_error", 64'(frame_error), 64'h0);
      check("rst_drop", 64'(frame_drop), 64'h0);

      // good frame, ready high: valid for exactly one cycle
      expect_ev(EV_DELIVER, f1);
      spi_send(64'(f1), FB);
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge int_osc);
         if (frame_valid) begin
            cyc = i;
            break;
         end
      end
      check("valid_latency", 64'(cyc), 64'(SYNC + 2));
      @(negedge int_osc);
      check("valid_consumed", 64'(frame_valid), 64'h0);
      cycles(10);

      // wrong lengths
      expect_ev(EV_ERROR, '0);
      spi_send(64'h7FFFFFFFFF, FB - 1);
      cycles(12);
      expect_ev(EV_ERROR, '0);
      spi_send(64'h1_5555_5555_55, FB + 1);
      cycles(12);
      check("len_valid", 64'(frame_valid), 64'h0);
      check("len_frame", 64'(frame), 64'(f1));

      // pending frame, sequencer stalled
      frame_ready = 1'b0;
      expect_ev(EV_DELIVER, fa);
      spi_send(64'(fa), FB);
      cycles(12);
`ifdef SPI_FRAME_OVERWRITE_EN
      expect_ev(EV_DROP, fb);
`else
      expect_ev(EV_DROP, fa);
`endif
      spi_send(64'(fb), FB);
      cycles(12);
      check("stall_valid", 64'(frame_valid), 64'h1);
`ifdef SPI_FRAME_OVERWRITE_EN
      check("stall_frame", 64'(frame), 64'(fb));
`else
      check("stall_frame", 64'(frame), 64'(fa));
`endif
      frame_ready = 1'b1;
      @(negedge int_osc);
      check("stall_consume", 64'(frame_valid), 64'h0);
      frame_ready = 1'b0;
      cycles(6);

      // ready rises in the CHECK cycle of the second frame
      expect_ev(EV_DELIVER, fa2);
      spi_send(64'(fa2), FB);
      cycles(12);
      expect_ev(EV_DELIVER, fb2);
      spi_send(64'(fb2), FB);
      cycles(SYNC + 1);
      frame_ready = 1'b1;
      @(negedge int_osc);
      check("race_valid", 64'(frame_valid), 64'h1);
      check("race_frame", 64'(frame), 64'(fb2));
      @(negedge int_osc);
      check("race_consume", 64'(frame_valid), 64'h0);
      cycles(8);

      // reset mid-transfer, released with ce high
      ce = 1'b1;
      cycles(HALF);
      spi_bits(64'(f6) >> 20, 20);
      reset = 1'b1;
      cycles(3);
      reset = 1'b0;
      spi_bits(64'(f6) & 64'hFFFFF, 20);
      cycles(HALF);
      ce = 1'b0;
      cycles(12);
      check("rstmid_valid", 64'(frame_valid), 64'h0);
      check("rstmid_frame", 64'(frame), 64'h0);
      expect_ev(EV_DELIVER, f6);
      spi_send(64'(f6), FB);
      cycles(12);
      check("rstmid_next", 64'(frame), 64'(f6));

      // ce pulse with no sck edges
      expect_ev(EV_ERROR, '0);
      ce = 1'b1;
      cycles(SYNC);
      check("zero_busy_pre", 64'(busy), 64'h0);
      @(negedge int_osc);
      check("zero_busy_on", 64'(busy), 64'h1);
      cycles(8);
      ce = 1'b0;
      cycles(SYNC);
      check("zero_busy_hold", 64'(busy), 64'h1);
      @(negedge int_osc);
      check("zero_busy_off", 64'(busy), 64'h0);
      cycles(12);

      check("sb_empty", 64'(sb.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
